// File: rtl/smm_pkg.sv
// rtl/smm_pkg.sv - shared types and constants for the Strassen tile sequencer
//
// Purpose: FSM state encoding, default element width and core latency,
// and lane index/offset helpers for the packed 2x2 tile bus.
// Ports: none (package).
package smm_pkg;

  localparam int SMM_DATAWIDTH = 32;
  localparam int SMM_LATENCY   = 2;

  // Packed 2x2 tile: lane n occupies bits [n*DW +: DW].
  localparam int SMM_LANES = 4;
  localparam int LANE_X00  = 0;
  localparam int LANE_X01  = 1;
  localparam int LANE_X10  = 2;
  localparam int LANE_X11  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } smm_state_e;

  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/smm_tile_ctrl_if.sv
// rtl/smm_tile_ctrl_if.sv - tile stream, core and result bundle for the sequencer
//
// Purpose: groups the input tile stream, the core drive/return signals and the
// accumulated-result stream.
// Modports:
//   slave  - the sequencer: consumes in_*, core_c, out_ready; drives the rest
//   master - the environment (tile fetch, core, result consumer)
interface smm_tile_ctrl_if
  import smm_pkg::*;
#(
  parameter int DATAWIDTH = SMM_DATAWIDTH
);
  localparam int BUSWIDTH = 4 * DATAWIDTH;

  logic                in_valid;
  logic                in_ready;
  logic [BUSWIDTH-1:0] in_a;
  logic [BUSWIDTH-1:0] in_b;
  logic                in_sel;
  logic                in_last;

  logic [BUSWIDTH-1:0] core_a;
  logic [BUSWIDTH-1:0] core_b;
  logic                core_load;
  logic                core_sel;
  logic [BUSWIDTH-1:0] core_c;

  logic                out_valid;
  logic                out_ready;
  logic [BUSWIDTH-1:0] out_c;
  logic [7:0]          out_count;
  logic                busy;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_last, core_c, out_ready,
    output in_ready, core_a, core_b, core_load, core_sel,
           out_valid, out_c, out_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, in_last, core_c, out_ready,
    input  in_ready, core_a, core_b, core_load, core_sel,
           out_valid, out_c, out_count, busy
  );

endinterface

// File: rtl/smm_acc4.sv
// rtl/smm_acc4.sv - four independent lane accumulators with load/add select
//
// Purpose: holds the running 2x2 tile sum. When en_i is high each lane either
// loads c_i (load_i=1) or adds c_i modulo 2^DATAWIDTH; lanes never carry into
// each other.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears all lanes)
//   en_i      - update this cycle
//   load_i    - 1: overwrite with c_i, 0: accumulate c_i
//   c_i       - packed tile to load/add
//   acc_o     - packed accumulated tile
module smm_acc4
  import smm_pkg::*;
#(
  parameter int DATAWIDTH = SMM_DATAWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   load_i,
  input  logic [4*DATAWIDTH-1:0] c_i,
  output logic [4*DATAWIDTH-1:0] acc_o
);

  logic [4*DATAWIDTH-1:0] acc_q;
  logic [4*DATAWIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      for (int l = 0; l < SMM_LANES; l++) begin
        // Each lane is sliced separately so the sum truncates per lane.
        if (load_i) begin
          acc_d[lane_lsb(l, DATAWIDTH) +: DATAWIDTH] = c_i[lane_lsb(l, DATAWIDTH) +: DATAWIDTH];
        end else begin
          acc_d[lane_lsb(l, DATAWIDTH) +: DATAWIDTH] =
            acc_q[lane_lsb(l, DATAWIDTH) +: DATAWIDTH] + c_i[lane_lsb(l, DATAWIDTH) +: DATAWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/smm_tile_ctrl.sv
// rtl/smm_tile_ctrl.sv - sequencer feeding the 2x2 Strassen core and summing its tiles
//
// Purpose: accepts one (A, B) tile pair at a time, pulses core load, waits the
// core latency, then loads or adds core_c into the accumulator. After the
// job's last tile the sum is presented until the consumer takes it.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   tile_if  - smm_tile_ctrl_if.slave: in_* tile stream, core_* drive/return,
//              out_* result stream, busy
module smm_tile_ctrl
  import smm_pkg::*;
#(
  parameter int DATAWIDTH = SMM_DATAWIDTH,
  parameter int LATENCY   = SMM_LATENCY
) (
  input  logic         clk,
  input  logic         rst,
  smm_tile_ctrl_if.slave tile_if
);

  localparam int BUSWIDTH = 4 * DATAWIDTH;
  localparam int WAITW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WAITW-1:0] WAIT_INIT = WAITW'(LATENCY - 1);

  smm_state_e          state_q, state_d;
  logic [WAITW-1:0]    wait_q, wait_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [BUSWIDTH-1:0] core_a_q, core_a_d;
  logic [BUSWIDTH-1:0] core_b_q, core_b_d;
  logic                sel_q, sel_d;
  logic [7:0]          count_q, count_d;
  logic                capture;
  logic [BUSWIDTH-1:0] acc;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    first_d  = first_q;
    last_d   = last_q;
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    sel_d    = sel_q;
    count_d  = count_q;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Operands and sel are only ever updated here, which keeps them
        // steady for the core while the tile is in flight.
        if (tile_if.in_valid) begin
          core_a_d = tile_if.in_a;
          core_b_d = tile_if.in_b;
          sel_d    = tile_if.in_sel;
          last_d   = tile_if.in_last;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          capture = 1'b1;
          first_d = 1'b0;
          if (first_q) begin
            count_d = 8'd1;
          end else if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          state_d = last_q ? ST_DONE : ST_IDLE;
        end else begin
          wait_d = wait_q - WAITW'(1);
        end
      end
      ST_DONE: begin
        if (tile_if.out_ready) begin
          first_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      core_a_q <= '0;
      core_b_q <= '0;
      sel_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      first_q  <= first_d;
      last_q   <= last_d;
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
    end
  end

  smm_acc4 #(
    .DATAWIDTH(DATAWIDTH)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (capture),
    .load_i (first_q),
    .c_i    (tile_if.core_c),
    .acc_o  (acc)
  );

  // in_ready is gated by rst so nothing is offered while reset is held.
  assign tile_if.in_ready  = (state_q == ST_IDLE) && !rst;
  assign tile_if.core_load = (state_q == ST_ISSUE);
  assign tile_if.core_a    = core_a_q;
  assign tile_if.core_b    = core_b_q;
  assign tile_if.core_sel  = sel_q;
  assign tile_if.out_valid = (state_q == ST_DONE);
  assign tile_if.out_c     = acc;
  assign tile_if.out_count = count_q;
  assign tile_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_smm_tile_ctrl.sv
// tb/tb_smm_tile_ctrl.sv - scoreboard bench for smm_tile_ctrl with a behavioural core
module tb_smm_tile_ctrl;
  import smm_pkg::*;

  localparam int DW  = 32;
  localparam int BW  = 4 * DW;
  localparam int LAT = SMM_LATENCY;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smm_tile_ctrl_if #(.DATAWIDTH(DW)) bus ();

  smm_tile_ctrl #(.DATAWIDTH(DW), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .tile_if (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Core stand-in: operands sampled on load, result valid LAT cycles later;
  // sel is applied combinationally at the output, like the real core.
  logic [BW-1:0] s1_a, s1_b, s2_a, s2_b;
  always @(posedge clk) begin
    if (rst) begin
      s1_a <= '0; s1_b <= '0; s2_a <= '0; s2_b <= '0;
    end else begin
      if (bus.core_load) begin
        s1_a <= bus.core_a;
        s1_b <= bus.core_b;
      end
      s2_a <= s1_a;
      s2_b <= s1_b;
    end
  end

  function automatic logic [DW-1:0] ln(input logic [BW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sel);
    logic [DW-1:0] c00, c01, c10, c11;
    c00 = ln(a, 0) * ln(b, 0) + ln(a, 1) * ln(b, 2);
    c01 = ln(a, 0) * ln(b, 1) + ln(a, 1) * ln(b, 3);
    c10 = ln(a, 2) * ln(b, 0) + ln(a, 3) * ln(b, 2);
    c11 = ln(a, 2) * ln(b, 1) + ln(a, 3) * ln(b, 3);
    return sel ? {c01, {DW{1'b0}}, c10, {DW{1'b0}}} : {c11, c10, c01, c00};
  endfunction

  assign bus.core_c = core_fn(s2_a, s2_b, bus.core_sel);

  // Reference model: block matrix sum over the job's tiles.
  typedef struct {
    logic [BW-1:0] c;
    int            cnt;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_acc[4];
  int            m_tiles = 0;
  int            last_hs_cyc = 0;
  int            load_cnt = 0;

  function automatic void model_tile(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sel);
    logic [DW-1:0] am[2][2], bm[2][2], p[2][2], t[4];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        am[i][j] = a[(2*i+j)*DW +: DW];
        bm[i][j] = b[(2*i+j)*DW +: DW];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        p[i][j] = '0;
        for (int k = 0; k < 2; k++) p[i][j] += am[i][k] * bm[k][j];
      end
    if (sel) begin
      t[0] = '0; t[1] = p[1][0]; t[2] = '0; t[3] = p[0][1];
    end else begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) t[2*i+j] = p[i][j];
    end
    for (int l = 0; l < 4; l++) m_acc[l] = (m_tiles == 0) ? t[l] : m_acc[l] + t[l];
    m_tiles++;
  endfunction

  function automatic void model_push();
    exp_t e;
    e.c   = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
    e.cnt = (m_tiles > 255) ? 255 : m_tiles;
    sb_q.push_back(e);
    m_tiles = 0;
  endfunction

  function automatic logic [BW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  // Monitor: pops the scoreboard on each result handshake and watches
  // load pulses, sel stability, result latency and backpressure holding.
  initial begin
    logic [BW-1:0] prev_oc;
    logic [7:0]    prev_cnt;
    logic          prev_ov, prev_load, sel_ref;
    int            sel_left;
    exp_t          e;
    prev_ov = 1'b0; prev_load = 1'b0; sel_ref = 1'b0; sel_left = 0;
    prev_oc = '0; prev_cnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0; prev_load = 1'b0; sel_left = 0;
      end else begin
        if (bus.core_load) begin
          load_cnt++;
          chk_int("core_load_width", int'(prev_load), 0);
          chk_int("core_load_timing", cyc - last_hs_cyc, 1);
          sel_ref  = bus.core_sel;
          sel_left = LAT;
        end else if (sel_left > 0) begin
          chk_int("core_sel_stable", int'(bus.core_sel), int'(sel_ref));
          sel_left--;
        end
        if (bus.out_valid) begin
          chk_int("in_ready_in_done", int'(bus.in_ready), 0);
          if (!prev_ov) begin
            chk_int("out_valid_latency", cyc - last_hs_cyc, LAT + 2);
          end else begin
            chk_bus("out_c_hold", bus.out_c, prev_oc);
            chk_int("out_count_hold", int'(bus.out_count), int'(prev_cnt));
          end
          if (bus.out_ready) begin
            if (sb_q.size() == 0) begin
              chk_int("unexpected_result", 1, 0);
            end else begin
              e = sb_q.pop_front();
              chk_bus("out_c", bus.out_c, e.c);
              chk_int("out_count", int'(bus.out_count), e.cnt);
            end
          end
        end
        prev_ov   = bus.out_valid;
        prev_oc   = bus.out_c;
        prev_cnt  = bus.out_count;
        prev_load = bus.core_load;
      end
    end
  end

  // Offers a tile and returns just after its accepting edge; in_valid stays
  // high between tiles of a job and drops after the last one.
  task automatic send_tile(input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic sel, input logic last, input bit chk_gap);
    int n;
    int prev;
    bus.in_a = a; bus.in_b = b; bus.in_sel = sel; bus.in_last = last;
    bus.in_valid = 1'b1;
    prev = last_hs_cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      chk_int("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    last_hs_cyc = cyc;
    if (chk_gap) chk_int("tile_period", last_hs_cyc - prev, LAT + 2);
    model_tile(a, b, sel);
    if (last) model_push();
    @(posedge clk);
    #1;
    if (last) bus.in_valid = 1'b0;
  endtask

  task automatic finish_job(input int hold);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk_int("out_valid_timeout", 0, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_int({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk_int({tag, "_busy"}, int'(bus.busy), 0);
    chk_int({tag, "_core_load"}, int'(bus.core_load), 0);
    chk_int({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk_int({tag, "_out_count"}, int'(bus.out_count), 0);
    chk_bus({tag, "_out_c"}, bus.out_c, '0);
    chk_bus({tag, "_core_a"}, bus.core_a, '0);
  endtask

  initial begin
    logic [BW-1:0] ta, tb, ti, tw;
    int lc0, ntile;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_sel = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_int("in_ready_during_rst", int'(bus.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk_idle_outputs("reset");

    ta = pack4(1, 2, 3, 4);
    tb = pack4(5, 6, 7, 8);

    // Single full tile.
    send_tile(ta, tb, 1'b0, 1'b1, 1'b0);
    finish_job(0);

    // Three tiles, continuous in_valid.
    lc0 = load_cnt;
    send_tile(ta, tb, 1'b0, 1'b0, 1'b0);
    send_tile(ta, tb, 1'b0, 1'b0, 1'b1);
    send_tile(ta, tb, 1'b0, 1'b1, 1'b1);
    finish_job(0);
    chk_int("load_pulses_3tile", load_cnt - lc0, 3);

    // Sparse tile.
    send_tile(ta, tb, 1'b1, 1'b1, 1'b0);
    finish_job(1);

    // Lane wrap-around.
    ti = pack4(1, 0, 0, 1);
    tw = pack4(32'h7FFFFFFF, 0, 0, 1);
    send_tile(ti, tw, 1'b0, 1'b0, 1'b0);
    send_tile(ti, tw, 1'b0, 1'b1, 1'b1);
    finish_job(0);

    // Backpressure, then a job that must start from a fresh accumulator.
    send_tile(tb, ta, 1'b0, 1'b1, 1'b0);
    finish_job(5);
    send_tile(ti, ta, 1'b0, 1'b1, 1'b0);
    finish_job(0);

    // Reset while a tile is waiting on the core.
    send_tile(ta, tb, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_int("busy_in_wait", int'(bus.busy), 1);
    rst = 1'b1; bus.in_valid = 1'b0;
    m_tiles = 0;
    @(posedge clk); #1 rst = 1'b0;
    #1 chk_idle_outputs("midrst");
    send_tile(tb, ta, 1'b1, 1'b1, 1'b0);
    finish_job(0);

    // Random jobs: mixed full/sparse tiles, random data and hold times.
    for (int j = 0; j < 20; j++) begin
      ntile = $urandom_range(1, 4);
      for (int t = 0; t < ntile; t++) begin
        send_tile({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)), (t == ntile - 1) ? 1'b1 : 1'b0, (t != 0) ? 1'b1 : 1'b0);
      end
      finish_job($urandom_range(0, 3));
    end

    // Long job: tile count saturates at 255.
    for (int t = 0; t < 260; t++) begin
      send_tile({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), (t == 259) ? 1'b1 : 1'b0, (t != 0) ? 1'b1 : 1'b0);
    end
    finish_job(0);

    repeat (3) @(posedge clk);
    chk_int("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/smm_tile_ctrl.md
# smm_tile_ctrl

Sequencer for the 2x2 Strassen tile multiplier core. It accepts a stream of (A, B) tile pairs over a valid/ready handshake and drives the core's `load`/`sel`/`A`/`B` inputs. It waits the core's fixed latency, then accumulates the core's `C_out` lane-wise across the tiles of a job, so that C_ij = Σ_k A_ik·B_kj for block matrix products. It sits between the tile-fetch logic and the multiplier core; one tile is in flight at a time.

## Interface
- `DATAWIDTH`, 32, element width; accumulation wraps mod 2^DATAWIDTH
- `BUSWIDTH`, 4*DATAWIDTH, packed 2x2 tile; lane0=[DW-1:0]=x00, lane1=x01, lane2=x10, lane3=x11
- `LATENCY`, 2, cycles from the core sampling `load` to `C_out` being valid

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high
- `in_valid` in 1: tile pair offered
- `in_ready` out 1: controller accepts a tile this cycle
- `in_a`, `in_b` in BUSWIDTH: tile operands
- `in_sel` in 1: 0 = full product, 1 = sparse mode (core emits lanes 1,3 only)
- `in_last` in 1: final tile of the job
- `core_a`, `core_b` out BUSWIDTH: to core `A`, `B`
- `core_load` out 1: to core `load`
- `core_sel` out 1: to core `sel`
- `core_c` in BUSWIDTH: from core `C_out`
- `out_valid` out 1: accumulated result available
- `out_ready` in 1: consumer accepts the result
- `out_c` out BUSWIDTH: accumulated tile
- `out_count` out 8: tiles summed into `out_c`; saturates at 255
- `busy` out 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`: register `in_a`, `in_b`, `in_sel` into `core_a`, `core_b`, `core_sel`; latch `in_last`; go to ISSUE.
- ISSUE
  - `core_load`=1 for exactly one cycle.
  - Load wait counter with LATENCY-1; go to WAIT.
- WAIT
  - Lasts LATENCY cycles.
  - On the final WAIT cycle's edge, capture `core_c` into the accumulator:
    - first tile of a job overwrites (acc = `core_c`);
    - later tiles add lane-wise, each lane DATAWIDTH bits, overflow wraps, no carry between lanes.
  - Increment `out_count`.
  - Go to DONE if the latched last flag is set, else IDLE.
- DONE
  - `out_valid`=1, `out_c`=acc, `in_ready`=0.
  - Hold until `out_ready`. On the handshake, set the first flag, go to IDLE.
  - `out_count` stays stable until the handshake; the next job's first capture reloads it to 1.
- `core_sel`, `core_a`, `core_b` change only on an input handshake. `core_sel` therefore stays constant from ISSUE through capture, which the core requires because its product and sum stages use `sel` combinationally.
- Sparse tiles are accumulated as delivered, with lanes 0 and 2 equal to zero. Full and sparse tiles may be mixed within one job.
- `core_load` is never asserted outside ISSUE.
- The core's reset is driven by the shared `rst`, not by this block.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, 1 on the first cycle after release. All other outputs reset to 0; the first flag is set; state is IDLE.
- Handshake at cycle t:
  - ISSUE (`core_load`=1) at t+1;
  - WAIT at t+2 .. t+1+LATENCY;
  - capture at the end of t+1+LATENCY.
- Tile period is LATENCY+2 cycles (4 at default).
- `out_valid` rises the cycle after the last tile's capture.
- `rst` mid-job: abandon the in-flight tile, drop `core_load`, clear the accumulator and `out_count`, return to IDLE.
- `in_valid` held high continuously: the next tile is accepted in the IDLE cycle after the capture.

## Structure
- Package `smm_pkg`:
  - state enum;
  - default DATAWIDTH;
  - lane index/offset constants;
  - default LATENCY.
- Sub-module `smm_acc4`: four independent DATAWIDTH lane adders with load/add select and enable.
- The FSM and counter live in `smm_tile_ctrl`. The core is instantiated alongside it, not inside it.

## Test plan
- Single full tile: A={1,2,3,4}, B={5,6,7,8} (lanes 0..3), last=1.
  - Required: `out_c`={19,22,43,50}, `out_count`=1.
  - `out_valid` exactly 4 cycles after the handshake cycle.
- Three-tile job, same operands each tile.
  - Required: `out_c`={57,66,129,150}, `out_count`=3.
  - `core_load` pulses exactly three times, each 1 cycle wide.
- Sparse tile: same A and B, `in_sel`=1.
  - Required: `out_c`={0,43,0,22}.
  - `core_sel` stable from ISSUE through capture.
- Wrap-around: A={1,0,0,1}, B={0x7FFFFFFF,0,0,1}, two tiles.
  - Required: lane0=0xFFFFFFFE, lane3=2, no spill into lane1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - Required: `out_valid` and `out_c` stable, `in_ready`=0.
  - After the handshake, the next job's first tile overwrites the accumulator.
- Reset in WAIT: assert `rst` for one cycle.
  - Required: all outputs 0 next cycle; `in_ready`=1 the cycle after release.
  - A subsequent single-tile job yields a clean result with no residue from the aborted tile.
